// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI-Lite register slave: response codes,
// FSM state encodings, register offsets and the byte-strobe merge helper.
// No ports; imported by the interface users, the top and the register bank.
package axi_lite_pkg;

  localparam logic [2:0] RESP_OKAY   = 3'd0;
  localparam logic [2:0] RESP_SLVERR = 3'd2;

  // Byte offsets of the four registers relative to BASE_ADDR.
  localparam logic [3:0] OFF_REG0 = 4'h0;
  localparam logic [3:0] OFF_REG1 = 4'h4;
  localparam logic [3:0] OFF_REG2 = 4'h8;
  localparam logic [3:0] OFF_REG3 = 4'hC;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_WAIT_DATA,
    WR_WAIT_ADDR,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

  // Replace the bytes of cur selected by strb with the matching bytes of nxt.
  function automatic logic [31:0] strb_merge(input logic [31:0] cur,
                                             input logic [31:0] nxt,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = nxt[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bus bundle (AW, W, B, AR, R channels) between a master and the slave.
// No logic, zero latency; valid/ready on every channel.
// Ports: master drives addresses/data/valids and B/R readies; slave the rest.
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
  logic                    s_axi_awvalid;
  logic                    s_axi_awready;
  logic [DATA_WIDTH-1:0]   s_axi_wdata;
  logic [DATA_WIDTH/8:0]   s_axi_wstrb;
  logic                    s_axi_wvalid;
  logic                    s_axi_wready;
  logic [RESP_WIDTH-1:0]   s_axi_bresp;
  logic                    s_axi_bvalid;
  logic                    s_axi_bready;
  logic [ADDR_WIDTH-1:0]   s_axi_araddr;
  logic                    s_axi_arvalid;
  logic                    s_axi_arready;
  logic [DATA_WIDTH-1:0]   s_axi_rdata;
  logic [RESP_WIDTH-1:0]   s_axi_rresp;
  logic                    s_axi_rvalid;
  logic                    s_axi_rready;

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/axi_lite_regbank.sv
// Register storage: REG0/REG1 with byte-strobe writes, OKAY-write counter, REG0+REG1 sum.
// Write takes effect on the edge wr_en is high; reads are combinational from the flops.
// No backpressure; the caller only raises wr_en for legal REG0/REG1 writes.
// Ports: clk/rst, wr_en/wr_sel(0=REG0,1=REG1)/wr_data/wr_strb in; reg0..reg3 out.
module axi_lite_regbank
  import axi_lite_pkg::*;
(
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  input  logic        wr_en,
  input  logic        wr_sel,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  output logic [31:0] reg0,
  output logic [31:0] reg1,
  output logic [31:0] reg2,
  output logic [31:0] reg3
);

  logic [31:0] reg0_q, reg0_d;
  logic [31:0] reg1_q, reg1_d;
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    reg0_d = reg0_q;
    reg1_d = reg1_q;
    cnt_d  = cnt_q;
    if (wr_en) begin
      if (wr_sel) reg1_d = strb_merge(reg1_q, wr_data, wr_strb);
      else        reg0_d = strb_merge(reg0_q, wr_data, wr_strb);
      // Every accepted write counts, including an all-zero strobe; wraps at 2^32.
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      reg0_q <= '0;
      reg1_q <= '0;
      cnt_q  <= '0;
    end else begin
      reg0_q <= reg0_d;
      reg1_q <= reg1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign reg0 = reg0_q;
  assign reg1 = reg1_q;
  assign reg2 = cnt_q;
  assign reg3 = reg0_q + reg1_q;

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite slave exposing four 32-bit registers; handshake FSMs and address decode.
// Write response one edge after the later AW/W handshake; read data one edge after AR.
// Holds bvalid/rvalid until bready/rready; AW/W/AR stalled while a response is pending.
// Ports: s_axi_aclk, s_axi_aresetn (async active-low), s_axi (axi_lite_if slave).
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    RESP_WIDTH = 3,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic       s_axi_aclk,
  input  logic       s_axi_aresetn,
  axi_lite_if.slave  s_axi
);

  // BASE_ADDR is 16-byte aligned, so the upper address bits select this block
  // and the low nibble is the register offset.
  function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4];
  endfunction

  function automatic logic wr_addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return addr_hit(a) && (a[3:0] == OFF_REG0 || a[3:0] == OFF_REG1);
  endfunction

  logic [31:0] reg0, reg1, reg2, reg3;

  // ---------------- write path ----------------
  wr_state_t                 wr_state_q, wr_state_d;
  logic                      awready_q, awready_d;
  logic                      wready_q, wready_d;
  logic                      bvalid_q, bvalid_d;
  logic [RESP_WIDTH-1:0]     bresp_q, bresp_d;
  logic [ADDR_WIDTH-1:0]     aw_addr_q, aw_addr_d;
  logic [DATA_WIDTH-1:0]     w_data_q, w_data_d;
  logic [DATA_WIDTH/8-1:0]   w_strb_q, w_strb_d;
  logic                      aw_hs, w_hs, wr_commit, wr_legal;
  logic [ADDR_WIDTH-1:0]     cm_addr;
  logic [DATA_WIDTH-1:0]     cm_data;
  logic [DATA_WIDTH/8-1:0]   cm_strb;
  logic                      unused_wstrb_msb;

  assign aw_hs = s_axi.s_axi_awvalid && awready_q;
  assign w_hs  = s_axi.s_axi_wvalid && wready_q;
  // The extra strobe bit only pads the bus width.
  assign unused_wstrb_msb = s_axi.s_axi_wstrb[DATA_WIDTH/8];

  always_comb begin
    wr_state_d = wr_state_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_commit  = 1'b0;
    // Commit operands come live from the bus unless that half was held earlier.
    cm_addr    = s_axi.s_axi_awaddr;
    cm_data    = s_axi.s_axi_wdata;
    cm_strb    = s_axi.s_axi_wstrb[DATA_WIDTH/8-1:0];
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_commit  = 1'b1;
          wr_state_d = WR_RESP;
        end else if (aw_hs) begin
          aw_addr_d  = s_axi.s_axi_awaddr;
          wr_state_d = WR_WAIT_DATA;
        end else if (w_hs) begin
          w_data_d   = s_axi.s_axi_wdata;
          w_strb_d   = s_axi.s_axi_wstrb[DATA_WIDTH/8-1:0];
          wr_state_d = WR_WAIT_ADDR;
        end
      end
      WR_WAIT_DATA: begin
        cm_addr = aw_addr_q;
        if (w_hs) begin
          wr_commit  = 1'b1;
          wr_state_d = WR_RESP;
        end
      end
      WR_WAIT_ADDR: begin
        cm_data = w_data_q;
        cm_strb = w_strb_q;
        if (aw_hs) begin
          wr_commit  = 1'b1;
          wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bvalid_q && s_axi.s_axi_bready) begin
          bvalid_d   = 1'b0;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
    wr_legal = wr_addr_ok(cm_addr);
    if (wr_commit) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_legal ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
    end
    // Readies are decoded from the next state so they come straight from flops.
    awready_d = (wr_state_d == WR_IDLE) || (wr_state_d == WR_WAIT_ADDR);
    wready_d  = (wr_state_d == WR_IDLE) || (wr_state_d == WR_WAIT_DATA);
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_state_q <= WR_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
    end
  end

  axi_lite_regbank u_regbank (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_aresetn (s_axi_aresetn),
    .wr_en         (wr_commit && wr_legal),
    .wr_sel        (cm_addr[3:0] == OFF_REG1),
    .wr_data       (cm_data),
    .wr_strb       (cm_strb),
    .reg0          (reg0),
    .reg1          (reg1),
    .reg2          (reg2),
    .reg3          (reg3)
  );

  // ---------------- read path ----------------
  rd_state_t               rd_state_q, rd_state_d;
  logic                    arready_q, arready_d;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [RESP_WIDTH-1:0]   rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]   rd_mux_data;
  logic [RESP_WIDTH-1:0]   rd_mux_resp;
  logic                    ar_hs;

  assign ar_hs = s_axi.s_axi_arvalid && arready_q;

  always_comb begin
    rd_mux_data = '0;
    rd_mux_resp = RESP_WIDTH'(RESP_SLVERR);
    if (addr_hit(s_axi.s_axi_araddr)) begin
      case (s_axi.s_axi_araddr[3:0])
        OFF_REG0: begin rd_mux_data = reg0; rd_mux_resp = RESP_WIDTH'(RESP_OKAY); end
        OFF_REG1: begin rd_mux_data = reg1; rd_mux_resp = RESP_WIDTH'(RESP_OKAY); end
        OFF_REG2: begin rd_mux_data = reg2; rd_mux_resp = RESP_WIDTH'(RESP_OKAY); end
        OFF_REG3: begin rd_mux_data = reg3; rd_mux_resp = RESP_WIDTH'(RESP_OKAY); end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs) begin
          // Sampled from the current flops, so a same-edge write is not visible.
          rdata_d    = rd_mux_data;
          rresp_d    = rd_mux_resp;
          rvalid_d   = 1'b1;
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (s_axi.s_axi_rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
    arready_d = (rd_state_d == RD_IDLE);
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign s_axi.s_axi_awready = awready_q;
  assign s_axi.s_axi_wready  = wready_q;
  assign s_axi.s_axi_bvalid  = bvalid_q;
  assign s_axi.s_axi_bresp   = bresp_q;
  assign s_axi.s_axi_arready = arready_q;
  assign s_axi.s_axi_rvalid  = rvalid_q;
  assign s_axi.s_axi_rdata   = rdata_q;
  assign s_axi.s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Self-checking bench for axi_lite_reg_slave: vector table through a response
// scoreboard, then hand sequences for W-before-AW, B backpressure, counter wrap
// and mid-transaction reset.
module tb_axi_lite_reg_slave;
  import axi_lite_pkg::*;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int RW  = 3;
  localparam int TMO = 50;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_WIDTH(RW)) bus ();

  axi_lite_reg_slave #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RESP_WIDTH (RW),
    .BASE_ADDR  (8'h00)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi         (bus)
  );

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [4:0]  strb;
    logic [2:0]  exp_resp;
    logic [31:0] exp_data;
    string       name;
  } vec_t;

  typedef struct {
    logic [2:0]  resp;
    logic [31:0] data;
    bit          chk_data;
    string       name;
  } exp_t;

  vec_t vecs [20];
  exp_t exp_q [$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(bit wr, logic [7:0] a, logic [31:0] d, logic [4:0] s,
                              logic [2:0] r, logic [31:0] x, string n);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.strb = s;
    v.exp_resp = r; v.exp_data = x; v.name = n;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out after %0d cycles", name, TMO);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s,
                           output logic [2:0] resp);
    bit aw_done, w_done, aw_now, w_now, ok;
    aw_done = 0; w_done = 0; ok = 0;
    bus.s_axi_awaddr  = a;
    bus.s_axi_wdata   = d;
    bus.s_axi_wstrb   = s;
    bus.s_axi_awvalid = 1'b1;
    bus.s_axi_wvalid  = 1'b1;
    for (int i = 0; i < TMO && !(aw_done && w_done); i++) begin
      aw_now = bus.s_axi_awvalid && bus.s_axi_awready;
      w_now  = bus.s_axi_wvalid && bus.s_axi_wready;
      tick();
      if (aw_now) begin aw_done = 1; bus.s_axi_awvalid = 1'b0; end
      if (w_now)  begin w_done = 1;  bus.s_axi_wvalid  = 1'b0; end
    end
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wvalid  = 1'b0;
    if (!(aw_done && w_done)) timeout("wr_handshake");
    bus.s_axi_bready = 1'b1;
    for (int i = 0; i < TMO; i++) begin
      if (bus.s_axi_bvalid) begin ok = 1; break; end
      tick();
    end
    if (!ok) timeout("wr_bvalid");
    resp = bus.s_axi_bresp;
    tick();
    bus.s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [2:0] resp);
    bit done, ok;
    done = 0; ok = 0;
    bus.s_axi_araddr  = a;
    bus.s_axi_arvalid = 1'b1;
    for (int i = 0; i < TMO && !done; i++) begin
      done = bus.s_axi_arready;
      tick();
    end
    bus.s_axi_arvalid = 1'b0;
    if (!done) timeout("rd_handshake");
    bus.s_axi_rready = 1'b1;
    for (int i = 0; i < TMO; i++) begin
      if (bus.s_axi_rvalid) begin ok = 1; break; end
      tick();
    end
    if (!ok) timeout("rd_rvalid");
    d    = bus.s_axi_rdata;
    resp = bus.s_axi_rresp;
    tick();
    bus.s_axi_rready = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [7:0] a,
                            input logic [31:0] exp_d, input logic [2:0] exp_r);
    logic [31:0] d;
    logic [2:0]  r;
    axi_read(a, d, r);
    check({name, "_data"}, d, exp_d);
    check({name, "_resp"}, 32'(r), 32'(exp_r));
  endtask

  initial begin
    logic [31:0] got_d;
    logic [2:0]  got_r;
    exp_t        e;

    vecs[0]  = mk(1, 8'h00, 32'h11223344, 5'h0F, RESP_OKAY,   32'h0,        "wr_reg0");
    vecs[1]  = mk(0, 8'h00, 32'h0,        5'h00, RESP_OKAY,   32'h11223344, "rd_reg0");
    vecs[2]  = mk(0, 8'h08, 32'h0,        5'h00, RESP_OKAY,   32'h00000001, "rd_cnt1");
    vecs[3]  = mk(1, 8'h04, 32'hAABBCCDD, 5'h05, RESP_OKAY,   32'h0,        "wr_reg1_strb5");
    vecs[4]  = mk(0, 8'h04, 32'h0,        5'h00, RESP_OKAY,   32'h00BB00DD, "rd_reg1");
    vecs[5]  = mk(0, 8'h0C, 32'h0,        5'h00, RESP_OKAY,   32'h11DD3421, "rd_sum");
    vecs[6]  = mk(1, 8'h00, 32'hFFFF0000, 5'h00, RESP_OKAY,   32'h0,        "wr_zero_strb");
    vecs[7]  = mk(0, 8'h00, 32'h0,        5'h00, RESP_OKAY,   32'h11223344, "rd_reg0_kept");
    vecs[8]  = mk(1, 8'h08, 32'h00001234, 5'h0F, RESP_SLVERR, 32'h0,        "wr_reg2_ro");
    vecs[9]  = mk(1, 8'h0C, 32'h00001234, 5'h0F, RESP_SLVERR, 32'h0,        "wr_reg3_ro");
    vecs[10] = mk(1, 8'h10, 32'hDEADBEEF, 5'h0F, RESP_SLVERR, 32'h0,        "wr_out_range");
    vecs[11] = mk(1, 8'h01, 32'hDEADBEEF, 5'h0F, RESP_SLVERR, 32'h0,        "wr_misalign");
    vecs[12] = mk(0, 8'h20, 32'h0,        5'h00, RESP_SLVERR, 32'h0,        "rd_out_range");
    vecs[13] = mk(0, 8'h02, 32'h0,        5'h00, RESP_SLVERR, 32'h0,        "rd_misalign");
    vecs[14] = mk(0, 8'h08, 32'h0,        5'h00, RESP_OKAY,   32'h00000003, "rd_cnt3");
    vecs[15] = mk(0, 8'h00, 32'h0,        5'h00, RESP_OKAY,   32'h11223344, "rd_reg0_after_err");
    vecs[16] = mk(1, 8'h00, 32'hFFFFFFFF, 5'h0F, RESP_OKAY,   32'h0,        "wr_reg0_ones");
    vecs[17] = mk(1, 8'h04, 32'h00000001, 5'h1F, RESP_OKAY,   32'h0,        "wr_reg1_one");
    vecs[18] = mk(0, 8'h0C, 32'h0,        5'h00, RESP_OKAY,   32'h00000000, "rd_sum_wrap");
    vecs[19] = mk(0, 8'h08, 32'h0,        5'h00, RESP_OKAY,   32'h00000005, "rd_cnt5");

    bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata  = '0; bus.s_axi_wstrb   = '0; bus.s_axi_wvalid = 1'b0;
    bus.s_axi_bready = 1'b0;
    bus.s_axi_araddr = '0; bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;

    // Reset state, then readies rise on the first edge after release.
    #12;
    check("rst_awready", 32'(bus.s_axi_awready), 32'h0);
    check("rst_wready",  32'(bus.s_axi_wready),  32'h0);
    check("rst_arready", 32'(bus.s_axi_arready), 32'h0);
    check("rst_bvalid",  32'(bus.s_axi_bvalid),  32'h0);
    check("rst_rvalid",  32'(bus.s_axi_rvalid),  32'h0);
    check("rst_bresp",   32'(bus.s_axi_bresp),   32'h0);
    check("rst_rdata",   bus.s_axi_rdata,        32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_awready_low", 32'(bus.s_axi_awready), 32'h0);
    tick();
    check("rel_awready", 32'(bus.s_axi_awready), 32'h1);
    check("rel_wready",  32'(bus.s_axi_wready),  32'h1);
    check("rel_arready", 32'(bus.s_axi_arready), 32'h1);

    // Table vectors through the scoreboard.
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back('{vecs[i].exp_resp, vecs[i].exp_data, !vecs[i].wr, vecs[i].name});
      got_d = '0;
      if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, got_r);
      else            axi_read(vecs[i].addr, got_d, got_r);
      e = exp_q.pop_front();
      check({e.name, "_resp"}, 32'(got_r), 32'(e.resp));
      if (e.chk_data) check({e.name, "_data"}, got_d, e.data);
    end

    // W leads AW by three cycles: REG1 byte0 <- 5.
    bus.s_axi_bready = 1'b1;
    bus.s_axi_wdata  = 32'h00000005;
    bus.s_axi_wstrb  = 5'h01;
    bus.s_axi_wvalid = 1'b1;
    check("wfirst_wready_pre", 32'(bus.s_axi_wready), 32'h1);
    tick();
    bus.s_axi_wvalid = 1'b0;
    check("wfirst_wready_drop", 32'(bus.s_axi_wready), 32'h0);
    check("wfirst_awready",     32'(bus.s_axi_awready), 32'h1);
    tick();
    tick();
    check("wfirst_no_bvalid", 32'(bus.s_axi_bvalid), 32'h0);
    bus.s_axi_awaddr  = 8'h04;
    bus.s_axi_awvalid = 1'b1;
    tick();
    bus.s_axi_awvalid = 1'b0;
    check("wfirst_bvalid", 32'(bus.s_axi_bvalid), 32'h1);
    check("wfirst_bresp",  32'(bus.s_axi_bresp),  32'(RESP_OKAY));
    tick();
    bus.s_axi_bready = 1'b0;
    check("wfirst_bvalid_clr", 32'(bus.s_axi_bvalid), 32'h0);
    read_check("wfirst_reg1", 8'h04, 32'h00000005, RESP_OKAY);
    read_check("wfirst_sum",  8'h0C, 32'h00000004, RESP_OKAY);

    // B backpressure: response held, next AW stalled until the B handshake.
    bus.s_axi_awaddr  = 8'h00; bus.s_axi_wdata = 32'h0000ABCD; bus.s_axi_wstrb = 5'h0F;
    bus.s_axi_awvalid = 1'b1;  bus.s_axi_wvalid = 1'b1;
    tick();
    check("bp_bvalid_rise", 32'(bus.s_axi_bvalid), 32'h1);
    bus.s_axi_awaddr = 8'h04; bus.s_axi_wdata = 32'h12345678;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_bvalid_hold", 32'(bus.s_axi_bvalid),  32'h1);
      check("bp_bresp_hold",  32'(bus.s_axi_bresp),   32'(RESP_OKAY));
      check("bp_awready_low", 32'(bus.s_axi_awready), 32'h0);
    end
    bus.s_axi_bready = 1'b1;
    tick();
    check("bp_b_done",      32'(bus.s_axi_bvalid),  32'h0);
    check("bp_awready_up",  32'(bus.s_axi_awready), 32'h1);
    tick();
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    check("bp_second_bvalid", 32'(bus.s_axi_bvalid), 32'h1);
    tick();
    bus.s_axi_bready = 1'b0;
    read_check("bp_reg1", 8'h04, 32'h12345678, RESP_OKAY);
    read_check("bp_reg0", 8'h00, 32'h0000ABCD, RESP_OKAY);
    read_check("bp_cnt",  8'h08, 32'h00000008, RESP_OKAY);

    // Counter wrap from all-ones.
    force dut.u_regbank.cnt_q = 32'hFFFFFFFF;
    tick();
    release dut.u_regbank.cnt_q;
    read_check("wrap_pre", 8'h08, 32'hFFFFFFFF, RESP_OKAY);
    axi_write(8'h00, 32'h00000001, 5'h0F, got_r);
    check("wrap_wr_resp", 32'(got_r), 32'(RESP_OKAY));
    read_check("wrap_post", 8'h08, 32'h00000000, RESP_OKAY);

    // Reset with AW held (WR_WAIT_DATA) and read data pending (RD_DATA).
    bus.s_axi_awaddr = 8'h00; bus.s_axi_awvalid = 1'b1;
    bus.s_axi_araddr = 8'h00; bus.s_axi_arvalid = 1'b1;
    tick();
    bus.s_axi_awvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
    check("mrst_pre_awready", 32'(bus.s_axi_awready), 32'h0);
    check("mrst_pre_rvalid",  32'(bus.s_axi_rvalid),  32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_bvalid",  32'(bus.s_axi_bvalid),  32'h0);
    check("mrst_rvalid",  32'(bus.s_axi_rvalid),  32'h0);
    check("mrst_arready", 32'(bus.s_axi_arready), 32'h0);
    check("mrst_wready",  32'(bus.s_axi_wready),  32'h0);
    check("mrst_reg0",    dut.u_regbank.reg0_q,   32'h0);
    check("mrst_rdata",   bus.s_axi_rdata,        32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.s_axi_bready = 1'b1; bus.s_axi_rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mrst_no_bvalid", 32'(bus.s_axi_bvalid), 32'h0);
      check("mrst_no_rvalid", 32'(bus.s_axi_rvalid), 32'h0);
    end
    check("mrst_wready_up", 32'(bus.s_axi_wready), 32'h1);
    bus.s_axi_bready = 1'b0; bus.s_axi_rready = 1'b0;
    read_check("mrst_reg0_rd", 8'h00, 32'h0, RESP_OKAY);
    read_check("mrst_cnt_rd",  8'h08, 32'h0, RESP_OKAY);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_slave.md
AXI_LITE_REG_SLAVE -- requirements
Module: axi_lite_reg_slave

Interface
REQ-001 DATA_WIDTH, 32, data bus width in bits; only 32 is supported.
REQ-002 ADDR_WIDTH, 8, address width in bits.
REQ-003 RESP_WIDTH, 3, response field width; the upper bits always drive 0.
REQ-004 BASE_ADDR, 0, byte address of REG0; must be 16-byte aligned.
REQ-005 s_axi_aclk  in  1  single clock for the whole block.
REQ-006 s_axi_aresetn  in  1  reset; asynchronous, active-low.
REQ-007 s_axi_awaddr  in  ADDR_WIDTH  write address.
REQ-008 s_axi_awvalid  in  1  write-address valid.
REQ-009 s_axi_awready  out  1  write-address ready.
REQ-010 s_axi_wdata  in  DATA_WIDTH  write data.
REQ-011 s_axi_wstrb  in  DATA_WIDTH/8+1  byte strobes; bit [DATA_WIDTH/8] is ignored (width matches bus).
REQ-012 s_axi_wvalid  in  1  write-data valid.
REQ-013 s_axi_wready  out  1  write-data ready.
REQ-014 s_axi_bresp  out  RESP_WIDTH  write response: 0 = OKAY, 2 = SLVERR.
REQ-015 s_axi_bvalid  out  1  write-response valid.
REQ-016 s_axi_bready  in  1  write-response ready.
REQ-017 s_axi_araddr  in  ADDR_WIDTH  read address.
REQ-018 s_axi_arvalid  in  1  read-address valid.
REQ-019 s_axi_arready  out  1  read-address ready.
REQ-020 s_axi_rdata  out  DATA_WIDTH  read data.
REQ-021 s_axi_rresp  out  RESP_WIDTH  read response: 0 = OKAY, 2 = SLVERR.
REQ-022 s_axi_rvalid  out  1  read-data valid.
REQ-023 s_axi_rready  in  1  read-data ready.

Function
REQ-024 Register map (offsets from BASE_ADDR):
- REG0 at +0: RW.
- REG1 at +4: RW.
- REG2 at +8: RO, count of OKAY writes.
- REG3 at +12: RO, REG0+REG1 modulo 2^32.
REQ-025 Write FSM states: WR_IDLE, WR_WAIT_DATA (AW held), WR_WAIT_ADDR (W held), WR_RESP.
REQ-026 awready is 1 only in WR_IDLE and WR_WAIT_ADDR; wready is 1 only in WR_IDLE and WR_WAIT_DATA; both are registered state decodes.
REQ-027 Transitions:
- AW and W handshakes in the same cycle in WR_IDLE go to WR_RESP.
- AW only goes to WR_WAIT_DATA; W only goes to WR_WAIT_ADDR.
- The missing handshake in a WAIT state goes to WR_RESP.
- bvalid&&bready in WR_RESP returns to WR_IDLE.
REQ-028 The register update and bvalid=1 occur at the edge completing the later of the AW/W handshakes; bvalid and bresp hold stable until bready.
REQ-029 A write updates only the bytes whose wstrb bit is set; a zero strobe is OKAY with no change and still counts in REG2.
REQ-030 A write to REG2/REG3, an address outside BASE_ADDR..BASE_ADDR+12, or an address with addr[1:0]!=0 returns SLVERR, changes nothing and does not count.
REQ-031 REG2 increments by 1 per OKAY write and wraps from 0xFFFFFFFF to 0.
REQ-032 Read FSM states: RD_IDLE (arready=1) and RD_DATA (rvalid=1).
REQ-033 At the AR handshake edge, rdata/rresp are loaded from the current register values; rvalid rises the next cycle, and the data holds until rready.
REQ-034 An illegal read address returns rdata=0 with rresp=SLVERR.
REQ-035 Read and write paths are independent; a read handshaked in the same cycle as a write commit returns the pre-write value.
REQ-036 The bready and rready inputs are honoured on the same edge; back-to-back transactions incur no idle cycle beyond the state return.

Reset
REQ-037 While aresetn=0, asynchronously:
- REG0, REG1, REG2, bresp, rdata and rresp are 0.
- bvalid, rvalid, awready, wready and arready are 0.
- Both FSMs are in IDLE.
REQ-038 A reset mid-transaction discards all held address/data with no response; the ready outputs rise on the first clock edge after deassertion.

Structure
REQ-039 The shared package axi_lite_pkg holds RESP_OKAY=0, RESP_SLVERR=2, the wr_state_t/rd_state_t enums and the register offset constants.
REQ-040 The register storage, byte-strobe merge, counter and adder live in sub-module axi_lite_regbank; the top module contains only the handshake FSMs and address decode.

Verification
REQ-041 Write 0x11223344 to +0 with wstrb=0xF, then read +0 -> bresp=0, rdata=0x11223344, rresp=0, REG2=1.
REQ-042 W presented 3 cycles before AW (REG1, data 0x5, wstrb=0x1) -> wready drops after the W handshake; bvalid rises 1 cycle after the AW handshake; REG3=REG0+5.
REQ-043 Write to +8, then read +0x20 and +0x2 -> each returns SLVERR; REG2 unchanged; rdata=0.
REQ-044 REG0=0xFFFFFFFF, REG1=1; read +12 -> 0x00000000 OKAY; preload REG2=0xFFFFFFFF via force, one OKAY write -> REG2=0.
REQ-045 Hold bready=0 for 5 cycles -> bvalid and bresp stable; awready=0 throughout; a new AW is accepted only after the B handshake.
REQ-046 Assert reset while in WR_WAIT_DATA and RD_DATA -> bvalid=rvalid=0 immediately; REG0 cleared; no response issued after deassertion.
